uart_mem_bridge: RTL

Debug and boot bridge that acts as a second initiator on the 16-bit memory bus. It is the counterpart to the bus responder in the system glue. It parses framed commands arriving from `uart_rx`, issues single read or write transactions with the `MEM_*` handshake, and returns status or read data through `uart_tx`. It is used to load RAM images and to peek/poke memory-mapped registers while the core is held in reset.

---
 rtl/uart_mem_bridge.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_bridge.sv
// Byte-framed debug bridge: parses R/W command frames from a UART receiver, runs one
// transaction on the 16-bit memory bus and returns status or read data to a UART transmitter.
module uart_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_rx_data_ready,
  input  logic [7:0]  I_rx_data,
  input  logic        I_tx_ready,
  output logic        O_tx_exec,
  output logic [7:0]  O_tx_data,
  input  logic        I_MEM_ready,
  output logic        O_MEM_exec,
  output logic        O_MEM_write,
  output logic [15:0] O_MEM_addr,
  output logic [15:0] O_MEM_data_out,
  input  logic [15:0] I_MEM_data_in,
  input  logic        I_MEM_data_ready,
  output logic        O_busy,
  output logic        O_overrun
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Loaded with TIMEOUT_CYCLES-2 so that the counter sits at 0 in the last BUS_WAIT cycle and
  // the 'T' byte can go out exactly TIMEOUT_CYCLES cycles after the strobe.
  localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT_CYCLES >= 2) ? CW'(TIMEOUT_CYCLES - 2) : '0;

  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TO  = 8'h54;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
    S_BUS_REQ, S_BUS_WAIT, S_RESP, S_TX_GUARD
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_hi_q, addr_hi_d;
  logic [7:0]      addr_lo_q, addr_lo_d;
  logic [7:0]      wdata_hi_q, wdata_hi_d;
  logic [7:0]      rdata_lo_q, rdata_lo_d;
  logic            second_q, second_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            mem_write_q, mem_write_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_data_q, mem_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            overrun_q, overrun_d;
  logic            tx_exec;
  logic            mem_exec;

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_hi_d   = addr_hi_q;
    addr_lo_d   = addr_lo_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_lo_d  = rdata_lo_q;
    second_d    = second_q;
    tx_data_d   = tx_data_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    tx_exec     = 1'b0;
    mem_exec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_rx_data_ready) begin
          if (I_rx_data == OP_RD || I_rx_data == OP_WR) begin
            is_wr_d = (I_rx_data == OP_WR);
            state_d = S_ADDR_H;
          end else begin
            tx_data_d = RSP_BAD;
            second_d  = 1'b0;
            state_d   = S_RESP;
          end
        end
      end
      S_ADDR_H: begin
        if (I_rx_data_ready) begin
          addr_hi_d = I_rx_data;
          state_d   = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (I_rx_data_ready) begin
          addr_lo_d = I_rx_data;
          if (is_wr_q) begin
            state_d = S_DATA_H;
          end else begin
            // Bus-side registers only change on entry to BUS_REQ, so they stay stable
            // from the strobe until the next command reaches the bus.
            mem_addr_d  = {addr_hi_q, I_rx_data};
            mem_write_d = 1'b0;
            state_d     = S_BUS_REQ;
          end
        end
      end
      S_DATA_H: begin
        if (I_rx_data_ready) begin
          wdata_hi_d = I_rx_data;
          state_d    = S_DATA_L;
        end
      end
      S_DATA_L: begin
        if (I_rx_data_ready) begin
          mem_addr_d  = {addr_hi_q, addr_lo_q};
          mem_data_d  = {wdata_hi_q, I_rx_data};
          mem_write_d = 1'b1;
          state_d     = S_BUS_REQ;
        end
      end
      S_BUS_REQ: begin
        if (I_MEM_ready && !I_reset) begin
          mem_exec = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = S_BUS_WAIT;
        end
      end
      S_BUS_WAIT: begin
        if (I_MEM_data_ready) begin
          if (mem_write_q) begin
            tx_data_d = RSP_OK;
            second_d  = 1'b0;
          end else begin
            tx_data_d  = I_MEM_data_in[15:8];
            rdata_lo_d = I_MEM_data_in[7:0];
            second_d   = 1'b1;
          end
          state_d = S_RESP;
        end else if (cnt_q == '0) begin
          tx_data_d = RSP_TO;
          second_d  = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (I_tx_ready && !I_reset) begin
          tx_exec = 1'b1;
          state_d = S_TX_GUARD;
        end
      end
      S_TX_GUARD: begin
        // The transmitter's ready may still read high in the cycle after exec; skip it.
        if (second_q) begin
          tx_data_d = rdata_lo_q;
          second_d  = 1'b0;
          state_d   = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (I_rx_data_ready &&
        (state_q inside {S_BUS_REQ, S_BUS_WAIT, S_RESP, S_TX_GUARD})) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_hi_q   <= '0;
      addr_lo_q   <= '0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
      second_q    <= 1'b0;
      tx_data_q   <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_hi_q   <= addr_hi_d;
      addr_lo_q   <= addr_lo_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_lo_q  <= rdata_lo_d;
      second_q    <= second_d;
      tx_data_q   <= tx_data_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign O_tx_exec      = tx_exec;
  assign O_tx_data      = tx_data_q;
  assign O_MEM_exec     = mem_exec;
  assign O_MEM_write    = mem_write_q;
  assign O_MEM_addr     = mem_addr_q;
  assign O_MEM_data_out = mem_data_q;
  assign O_busy         = (state_q != S_IDLE);
  assign O_overrun      = overrun_q;

endmodule
